// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between N_REQ writeback requesters.
// Registered write port (one cycle after acceptance); optional conflict counter under RF_WB_ARB_STATS_EN.
module rf_wb_arbiter #(
    parameter int ADDR_WDTH = 5,
    parameter int DATA_WDTH = 32,
    parameter int N_REQ     = 3
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [N_REQ-1:0]              req_valid_i,
    input  logic [N_REQ*ADDR_WDTH-1:0]    req_addr_i,
    input  logic [N_REQ*DATA_WDTH-1:0]    req_data_i,
    output logic [N_REQ-1:0]              req_ready_o,
    input  logic                          hold_i,
    output logic                          we_o,
    output logic [ADDR_WDTH-1:0]          ad_o,
    output logic [DATA_WDTH-1:0]          wd_o
`ifdef RF_WB_ARB_STATS_EN
    ,
    output logic [15:0]                   conflict_cnt_o
`endif
);

    localparam int PTR_W = $clog2(N_REQ);

    logic [PTR_W-1:0]     ptr_q;
    logic [PTR_W-1:0]     ptr_nxt;
    logic [PTR_W-1:0]     gnt_idx;
    logic [N_REQ-1:0]     grant;
    logic                 xfer;
    logic [ADDR_WDTH-1:0] gnt_addr;
    logic [DATA_WDTH-1:0] gnt_data;

    // Scan from ptr_q with wrap; ready is suppressed in reset and during hold.
    always_comb begin
        int idx;
        idx     = 0;
        grant   = '0;
        gnt_idx = '0;
        xfer    = 1'b0;
        if (rst_ni && !hold_i) begin
            for (int i = 0; i < N_REQ; i++) begin
                idx = int'(ptr_q) + i;
                if (idx >= N_REQ) begin
                    idx = idx - N_REQ;
                end
                if (!xfer && req_valid_i[idx]) begin
                    xfer        = 1'b1;
                    grant[idx]  = 1'b1;
                    gnt_idx     = PTR_W'(idx);
                end
            end
        end
    end

    assign req_ready_o = grant;
    assign gnt_addr    = req_addr_i[int'(gnt_idx)*ADDR_WDTH +: ADDR_WDTH];
    assign gnt_data    = req_data_i[int'(gnt_idx)*DATA_WDTH +: DATA_WDTH];
    assign ptr_nxt     = (gnt_idx == PTR_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;

    // Writes to x0 are accepted and advance the pointer but never reach the port.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
            we_o  <= 1'b0;
            ad_o  <= '0;
            wd_o  <= '0;
        end else begin
            we_o <= 1'b0;
            if (xfer) begin
                ptr_q <= ptr_nxt;
                if (gnt_addr != '0) begin
                    we_o <= 1'b1;
                    ad_o <= gnt_addr;
                    wd_o <= gnt_data;
                end
            end
        end
    end

`ifdef RF_WB_ARB_STATS_EN
    logic conflict;
    assign conflict = !hold_i && ($countones(req_valid_i) >= 2);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            conflict_cnt_o <= '0;
        end else if (conflict && conflict_cnt_o != 16'hFFFF) begin
            conflict_cnt_o <= conflict_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port (we3/ad3/wd3) between N_REQ writeback requesters, for example ALU, load unit and CSR unit.
- Uses round-robin arbitration with valid/ready handshakes on each requester.
- Drives the write port from registered outputs, so writes reach the register file one cycle after acceptance.
- Sits between the execute/memory writeback stages and reg_file.

Parameters:
- ADDR_WDTH, 5, register address width.
- DATA_WDTH, 32, register data width.
- N_REQ, 3, number of writeback requesters (at least 2). Index 0 is the ALU, 1 the load unit, 2 the CSR unit.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- req_valid_i  input  N_REQ  per-requester write request valid.
- req_addr_i  input  N_REQ*ADDR_WDTH  per-requester destination register, packed; requester k occupies slice k.
- req_data_i  input  N_REQ*DATA_WDTH  per-requester write data, packed; requester k occupies slice k.
- req_ready_o  output  N_REQ  per-requester accept; combinational.
- hold_i  input  1  pipeline freeze; while high, no request is accepted.
- we_o  output  1  to reg_file we3_i.
- ad_o  output  ADDR_WDTH  to reg_file ad3_i.
- wd_o  output  DATA_WDTH  to reg_file wd3_i.

Behaviour:
- Reset (async, rst_ni low):
  - we_o=0, ad_o=0, wd_o=0, ptr_q=0.
  - req_ready_o=0 while rst_ni is low.
- Arbitration (combinational, each cycle hold_i=0):
  - Scan requesters starting at index ptr_q, wrapping modulo N_REQ.
  - The first k with req_valid_i[k]=1 is granted; req_ready_o[k]=1.
  - All other req_ready_o bits are 0.
  - At most one ready bit is high in any cycle.
- Handshake:
  - A transfer occurs when valid and ready are both high at the clock edge.
  - A requester that is not granted holds valid, addr and data stable until accepted.
  - Dropping valid before acceptance is legal; the request is lost and there is no side effect.
- Pointer update:
  - On an accepted transfer from k, ptr_q <= (k+1) mod N_REQ.
  - With no transfer, ptr_q holds.
  - Wrap: k = N_REQ-1 gives ptr_q=0.
- Output register, latency 1:
  - Transfer from k with addr != 0: we_o<=1, ad_o<=addr_k, wd_o<=data_k.
  - Transfer with addr == 0 (x0): the request is accepted and ready is high, but we_o<=0. The pointer still advances.
  - No transfer: we_o<=0; ad_o and wd_o hold their last values.
  - we_o is a single-cycle pulse per accepted write.
- hold_i=1:
  - All req_ready_o are 0.
  - No transfer; ptr_q holds.
  - we_o<=0 on the next edge.
  - A write already registered in the cycle before hold rises still issues.
- Simultaneous requests:
  - Exactly one is served per cycle.
  - With all N_REQ valid continuously, grants rotate 0,1,2,0,... starting from ptr_q.
  - Worst-case wait for any requester is N_REQ-1 cycles.
- Reset mid-operation:
  - A pending we_o pulse is cleared immediately (asynchronously); that write is dropped.
  - ptr_q returns to 0.
  - After reset deassertion, the first grant starts from requester 0.
- Duplicate addresses from different requesters in consecutive cycles:
  - Written in grant order; the later write wins.
  - No merging or coalescing.

Optional Feature:
- Macro: RF_WB_ARB_STATS_EN.
- Defined:
  - Adds output conflict_cnt_o, 16 bits.
  - Increments by 1 each cycle with rst_ni=1, hold_i=0 and two or more req_valid_i bits high.
  - Saturates at 16'hFFFF.
  - Reset value 0; cleared asynchronously by rst_ni.
- Undefined:
  - Port and counter are absent.
  - Arbitration behaviour is identical.

Test Plan:
- Reset, then single requester 1 valid with addr=5, data=32'hDEADBEEF for one cycle:
  - req_ready_o=3'b010 that cycle.
  - Next cycle: we_o=1, ad_o=5, wd_o=32'hDEADBEEF.
  - Following cycle: we_o=0; ptr_q=2.
- All three valid continuously for 6 cycles after reset, addrs 1/2/3:
  - Grant sequence 0,1,2,0,1,2.
  - we_o high 6 consecutive cycles with ad_o 1,2,3,1,2,3.
- Requester 0 valid with addr=0, data=32'h1234:
  - req_ready_o[0]=1 and ptr_q advances to 1.
  - we_o stays 0 the next cycle.
- Requesters 0 and 2 valid, hold_i=1 for 3 cycles, then hold_i=0:
  - No ready and we_o=0 during hold.
  - After release, requester 0 is granted, then requester 2 on the next cycle.
- Assert rst_ni=0 asynchronously mid-cycle, right after a transfer edge, while we_o=1:
  - we_o, ad_o, wd_o drop to 0 immediately, without waiting for a clock edge.
  - After release, requester 2 valid alone is granted (ptr irrelevant), then ptr_q=0.
- With RF_WB_ARB_STATS_EN, 2 requesters valid for 10 cycles:
  - conflict_cnt_o=10.
  - Forcing 70000 conflict cycles gives conflict_cnt_o=16'hFFFF.
